// File: rtl/intt_butterfly_gs_pipe.sv
// Gentleman-Sande inverse-NTT butterfly with a four-stage valid/ready pipeline.
// Produces (A+B) mod Q and ((A-B)*Wk_inv) mod Q, optionally scaled by N^-1 mod Q.
module intt_butterfly_gs_pipe #(
    parameter int W     = 32,
    parameter int Q     = 40961,
    parameter int N_INV = 40921
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A_in,
    input  logic [W-1:0] B_in,
    input  logic [W-1:0] Wk_inv,
    input  logic         scale_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] A_out,
    output logic [W-1:0] B_out
);

    localparam logic [W:0]     Q_S  = (W+1)'(Q);
    localparam logic [W-1:0]   Q_W  = W'(Q);
    localparam logic [2*W-1:0] Q_D  = (2*W)'(Q);
    localparam logic [W-1:0]   NI_W = W'(N_INV);

    logic stall;
    logic advance;

    logic           v1, v2, v3;
    logic [W-1:0]   sum1, diff1, w1;
    logic           scale1;
    logic [2*W-1:0] prod2;
    logic [W-1:0]   sum2;
    logic           scale2;
    logic [2*W-1:0] sum_k3, p_k3;

    logic [W:0]     sum_raw;
    logic [W-1:0]   sum_mod, diff_mod;
    logic [W-1:0]   p_mod, k_mult;
    logic [2*W-1:0] sum_k, p_k;

    // The whole pipe moves in lockstep; only a blocked output freezes it.
    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = advance;

    always_comb begin
        sum_raw  = {1'b0, A_in} + {1'b0, B_in};
        sum_mod  = (sum_raw >= Q_S) ? W'(sum_raw - Q_S) : W'(sum_raw);
        diff_mod = (A_in < B_in) ? (A_in - B_in + Q_W) : (A_in - B_in);
    end

    // Scaling by 1 keeps both final reductions on one path whether or not scale is requested.
    always_comb begin
        p_mod  = W'(prod2 % Q_D);
        k_mult = scale2 ? NI_W : W'(1);
        sum_k  = {{W{1'b0}}, sum2} * {{W{1'b0}}, k_mult};
        p_k    = {{W{1'b0}}, p_mod} * {{W{1'b0}}, k_mult};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
        end else if (advance) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
        end
    end

    // Data registers load only when a valid item moves in, so bubbles leave old data in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum1   <= '0;
            diff1  <= '0;
            w1     <= '0;
            scale1 <= 1'b0;
            prod2  <= '0;
            sum2   <= '0;
            scale2 <= 1'b0;
            sum_k3 <= '0;
            p_k3   <= '0;
            A_out  <= '0;
            B_out  <= '0;
        end else if (advance) begin
            if (in_valid) begin
                sum1   <= sum_mod;
                diff1  <= diff_mod;
                w1     <= Wk_inv;
                scale1 <= scale_in;
            end
            if (v1) begin
                prod2  <= {{W{1'b0}}, diff1} * {{W{1'b0}}, w1};
                sum2   <= sum1;
                scale2 <= scale1;
            end
            if (v2) begin
                sum_k3 <= sum_k;
                p_k3   <= p_k;
            end
            if (v3) begin
                A_out <= W'(sum_k3 % Q_D);
                B_out <= W'(p_k3 % Q_D);
            end
        end
    end

endmodule

// File: tb/tb_intt_butterfly_gs_pipe.sv
// Directed bench for intt_butterfly_gs_pipe: latency, modular boundaries, stall, async reset
// and a short randomized scoreboard run.
module tb_intt_butterfly_gs_pipe;

    localparam int W = 32;
    localparam int Q = 40961;
    localparam int NV = 9;
    localparam int NRAND = 300;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A_in, B_in, Wk_inv;
    logic         scale_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] A_out, B_out;

    int checks = 0;
    int errors = 0;

    intt_butterfly_gs_pipe #(.W(W), .Q(Q), .N_INV(40921)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .A_in(A_in), .B_in(B_in), .Wk_inv(Wk_inv), .scale_in(scale_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .A_out(A_out), .B_out(B_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int a, input int b, input int w, input logic s);
        in_valid = v;
        A_in     = W'(a);
        B_in     = W'(b);
        Wk_inv   = W'(w);
        scale_in = s;
    endtask

    // Independent arithmetic reference for the randomized run.
    function automatic void model(input longint a, input longint b, input longint w,
                                  input bit s, output int ea, output int eb);
        longint k;
        k  = s ? 64'd40921 : 64'd1;
        ea = int'((((a + b) % Q) * k) % Q);
        eb = int'((((((a - b + Q) % Q) * w) % Q) * k) % Q);
    endfunction

    int va[NV], vb[NV], vw[NV], ea[NV], eb[NV];
    bit vs[NV];

    initial begin
        int sent, rcv, ia, ib;
        logic [W-1:0] held_a, held_b;
        int qa[$], qb[$];
        int ra, rb, rw;
        bit rs;

        va = '{3, 40960, 1024, 1, 100, 7, 40960, 2, 40000};
        vb = '{5, 40960, 0, 1, 7, 100, 1, 1, 0};
        vw = '{1, 1, 1, 7, 0, 1, 2, 3, 40000};
        vs = '{0, 0, 1, 1, 0, 0, 0, 1, 0};
        ea = '{8, 40959, 1, 40881, 107, 107, 0, 40841, 40000};
        eb = '{40959, 0, 1, 0, 0, 40868, 40957, 40841, 22379};

        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 0, 0, 0, 1'b0);
        #12;
        check("reset_out_valid", {31'b0, out_valid}, 0);
        check("reset_A_out", A_out, 0);
        check("reset_B_out", B_out, 0);
        reset = 1'b0;
        tick();
        check("post_reset_in_ready", {31'b0, in_ready}, 1);

        // Single op: result appears after four edges and lasts one cycle.
        drive(1'b1, 5, 3, 2, 1'b0);
        tick();
        drive(1'b0, 0, 0, 0, 1'b0);
        tick();
        tick();
        check("lat_not_early", {31'b0, out_valid}, 0);
        tick();
        check("lat_valid", {31'b0, out_valid}, 1);
        check("lat_A", A_out, 8);
        check("lat_B", B_out, 4);
        tick();
        check("lat_one_cycle", {31'b0, out_valid}, 0);

        // Back-to-back boundary vectors.
        for (int c = 0; c < NV + 3; c++) begin
            if (c < NV) drive(1'b1, va[c], vb[c], vw[c], vs[c]);
            else        drive(1'b0, 0, 0, 0, 1'b0);
            tick();
            if (c >= 3) begin
                check($sformatf("vec%0d_valid", c - 3), {31'b0, out_valid}, 1);
                check($sformatf("vec%0d_A", c - 3), A_out, ea[c - 3]);
                check($sformatf("vec%0d_B", c - 3), B_out, eb[c - 3]);
            end
        end
        drive(1'b0, 0, 0, 0, 1'b0);
        tick();
        check("stream_drained", {31'b0, out_valid}, 0);

        // Six ops with a three-cycle downstream stall.
        sent = 0;
        rcv = 0;
        held_a = '0;
        held_b = '0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 6 && c <= 8);
            if (sent < 6) drive(1'b1, sent + 10, sent, 5, 1'b0);
            else          drive(1'b0, 0, 0, 0, 1'b0);
            #1;
            if (c == 6) begin
                held_a = A_out;
                held_b = B_out;
                check("stall_valid", {31'b0, out_valid}, 1);
            end
            if (c >= 6 && c <= 8) begin
                check($sformatf("stall_in_ready_c%0d", c), {31'b0, in_ready}, 0);
                check($sformatf("stall_hold_A_c%0d", c), A_out, held_a);
                check($sformatf("stall_hold_B_c%0d", c), B_out, held_b);
            end
            if (out_valid && out_ready) begin
                if (rcv < 6) begin
                    check($sformatf("stall_res%0d_A", rcv), A_out, 2 * rcv + 10);
                    check($sformatf("stall_res%0d_B", rcv), B_out, 50);
                end else begin
                    check("stall_extra_output", {31'b0, out_valid}, 0);
                end
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        check("stall_count", rcv, 6);

        // Async reset with three ops in flight.
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 20 + c, 1, 3, 1'b0);
            tick();
        end
        drive(1'b0, 0, 0, 0, 1'b0);
        tick();
        check("pre_reset_valid", {31'b0, out_valid}, 1);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_valid", {31'b0, out_valid}, 0);
        check("async_reset_A", A_out, 0);
        check("async_reset_B", B_out, 0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("post_reset_idle_c%0d", c), {31'b0, out_valid}, 0);
        end

        // Randomized handshakes against the reference model.
        sent = 0;
        rcv = 0;
        for (int c = 0; c < 4000 && (sent < NRAND || qa.size() > 0); c++) begin
            ra = int'($urandom_range(Q - 1, 0));
            rb = int'($urandom_range(Q - 1, 0));
            rw = int'($urandom_range(Q - 1, 0));
            rs = 1'($urandom_range(1, 0));
            drive((sent < NRAND) && ($urandom_range(3, 0) != 0), ra, rb, rw, rs);
            out_ready = ($urandom_range(3, 0) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (qa.size() > 0) begin
                    ia = qa.pop_front();
                    ib = qb.pop_front();
                    check($sformatf("rand%0d_A", rcv), A_out, ia);
                    check($sformatf("rand%0d_B", rcv), B_out, ib);
                end else begin
                    check("rand_spurious_out", {31'b0, out_valid}, 0);
                end
                rcv++;
            end
            if (in_valid && in_ready) begin
                model(ra, rb, rw, rs, ia, ib);
                qa.push_back(ia);
                qb.push_back(ib);
                sent++;
            end
            @(posedge clk);
            #1;
        end
        check("rand_received", rcv, NRAND);
        check("rand_queue_empty", qa.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
